// File: rtl/birotr_pipe_if.sv
// birotr_pipe_if -- valid/ready bus for the bit-interleaved rotator.
//   Parameter HALF_W : width of each interleaved half (SW = log2(2*HALF_W)).
//   Input side  : din_valid, din_ready, din, shift, dir.
//   Output side : dout_valid, dout_ready, dout.
//   master modport : the producer/consumer around the rotator.
//   slave modport  : the rotator itself.
interface birotr_pipe_if #(
  parameter int HALF_W = 32
) ();
  localparam int SW = $clog2(2 * HALF_W);

  logic                  din_valid;
  logic                  din_ready;
  logic [2*HALF_W-1:0]   din;
  logic [SW-1:0]         shift;
  logic                  dir;
  logic                  dout_valid;
  logic                  dout_ready;
  logic [2*HALF_W-1:0]   dout;

  modport master (
    output din_valid, din, shift, dir, dout_ready,
    input  din_ready, dout_valid, dout
  );

  modport slave (
    input  din_valid, din, shift, dir, dout_ready,
    output din_ready, dout_valid, dout
  );
endinterface

// File: rtl/birotr_pipe.sv
// birotr_pipe -- two-stage pipelined rotator for a bit-interleaved word.
//   din holds a 2*HALF_W-bit logical word split into even bits (low half)
//   and odd bits (high half); dout is that logical word rotated right by
//   r (dir=0: r=shift, dir=1: r=-shift mod 2*HALF_W), re-interleaved.
// Ports:
//   clk      : clock, rising edge
//   rst      : asynchronous active-high reset
//   bus      : birotr_pipe_if.slave (din/dout valid-ready handshakes)
//   op_count : completed output transfers (16-bit, wrapping)
// Optional feature: define BIROTR_PIPE_OPCNT_EN to build the transfer
// counter; otherwise op_count is constant zero.
module birotr_pipe #(
  parameter int HALF_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  birotr_pipe_if.slave      bus,
  output logic [15:0]       op_count
);
  localparam int W  = 2 * HALF_W;
  localparam int SW = $clog2(W);
  localparam int HW = $clog2(HALF_W);

  // Rotation through a doubled word: the amount is always < HALF_W, so a
  // zero amount returns the half unchanged and nothing shifts out to zero.
  function automatic logic [HALF_W-1:0] rotr(input logic [HALF_W-1:0] x,
                                             input logic [HW-1:0]     a);
    logic [2*HALF_W-1:0] dbl;
    dbl = {x, x} >> a;
    return dbl[HALF_W-1:0];
  endfunction

  // Stage 1 state
  logic              s1_valid_q, s1_valid_d;
  logic [SW-1:0]     s1_r_q,     s1_r_d;
  logic              s1_swap_q,  s1_swap_d;
  logic [HALF_W-1:0] s1_lo_q,    s1_lo_d;
  logic [HALF_W-1:0] s1_hi_q,    s1_hi_d;
  // Stage 2 state
  logic              s2_valid_q, s2_valid_d;
  logic [W-1:0]      dout_q,     dout_d;

  logic              s2_can_load;
  logic              s1_load;
  logic              s1_drain;
  logic [SW-1:0]     r_in;
  logic [HW-1:0]     h_lo;
  logic [HW-1:0]     h_hi;

  assign s2_can_load   = !s2_valid_q || bus.dout_ready;
  assign bus.din_ready = !s1_valid_q || s2_can_load;
  assign s1_load       = bus.din_valid && bus.din_ready;
  assign s1_drain      = s1_valid_q && s2_can_load;
  assign bus.dout_valid = s2_valid_q;
  assign bus.dout       = dout_q;

  // Left rotation is the two's-complement right amount, wrapping mod W.
  assign r_in = bus.dir ? ((~bus.shift) + SW'(1)) : bus.shift;

  // An odd r moves odd bits into even positions, so the halves trade
  // places and the (new) high half rotates one extra position.
  assign h_lo = s1_r_q[SW-1:1];
  assign h_hi = h_lo + HW'(s1_swap_q);

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_r_d     = s1_r_q;
    s1_swap_d  = s1_swap_q;
    s1_lo_d    = s1_lo_q;
    s1_hi_d    = s1_hi_q;
    s2_valid_d = s2_valid_q;
    dout_d     = dout_q;

    if (s1_load) begin
      s1_valid_d = 1'b1;
      s1_r_d     = r_in;
      s1_swap_d  = r_in[0];
      s1_lo_d    = r_in[0] ? bus.din[W-1:HALF_W]  : bus.din[HALF_W-1:0];
      s1_hi_d    = r_in[0] ? bus.din[HALF_W-1:0]  : bus.din[W-1:HALF_W];
    end else if (s1_drain) begin
      s1_valid_d = 1'b0;
    end

    if (s1_drain) begin
      s2_valid_d = 1'b1;
      dout_d     = {rotr(s1_hi_q, h_hi), rotr(s1_lo_q, h_lo)};
    end else if (bus.dout_ready) begin
      s2_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_r_q     <= '0;
      s1_swap_q  <= 1'b0;
      s1_lo_q    <= '0;
      s1_hi_q    <= '0;
      s2_valid_q <= 1'b0;
      dout_q     <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_r_q     <= s1_r_d;
      s1_swap_q  <= s1_swap_d;
      s1_lo_q    <= s1_lo_d;
      s1_hi_q    <= s1_hi_d;
      s2_valid_q <= s2_valid_d;
      dout_q     <= dout_d;
    end
  end

`ifdef BIROTR_PIPE_OPCNT_EN
  logic [15:0] op_cnt_q, op_cnt_d;

  always_comb begin
    op_cnt_d = op_cnt_q;
    if (s2_valid_q && bus.dout_ready) op_cnt_d = op_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) op_cnt_q <= '0;
    else     op_cnt_q <= op_cnt_d;
  end

  assign op_count = op_cnt_q;
`else
  assign op_count = '0;
`endif

endmodule

// File: doc/birotr_pipe.md
BIROTR_PIPE -- requirements
Module: birotr_pipe

Interface
REQ-001 SHALL have parameter HALF_W, default 32: bit width of each interleaved half; power of two, 4 to 64.
REQ-002 SHALL derive SW = log2(2*HALF_W) internally: width of the shift amount.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 din_valid  input  1  input word and command are valid.
REQ-006 din_ready  output  1  block accepts the input this cycle.
REQ-007 din  input  2*HALF_W  interleaved word: i0 = din[HALF_W-1:0] (even bits), i1 = upper half (odd bits).
REQ-008 shift  input  SW  rotation amount on the interleaved word, 0 to 2*HALF_W-1.
REQ-009 dir  input  1  0 = rotate right, 1 = rotate left.
REQ-010 dout_valid  output  1  dout holds a result.
REQ-011 dout_ready  input  1  downstream accepts dout.
REQ-012 dout  output  2*HALF_W  rotated interleaved word.
REQ-013 op_count  output  16  completed output transfers (see Configuration).

Function
REQ-014 Effective right amount: r = shift if dir=0; r = (2*HALF_W - shift) mod 2*HALF_W if dir=1.
REQ-015 With h = r>>1, r even: dout low half = rotr(i0,h); dout high half = rotr(i1,h).
REQ-016 With h = r>>1, r odd: dout low half = rotr(i1,h); dout high half = rotr(i0,(h+1) mod HALF_W).
REQ-017 Rotation by 0 within a half SHALL give that half unchanged; no shift by HALF_W may produce zeros.
REQ-018 Two-stage pipeline.
- Stage 1 registers: r, the swap decision, and the two selected halves.
- Stage 2 registers: the rotated result on dout.
REQ-019 Each stage SHALL load when its input is valid and the stage is empty or is being drained the same cycle.
REQ-020 din_ready = !s1_valid || s2_can_load; dout_valid = s2_valid.
REQ-021 Latency: an input accepted in cycle N SHALL appear on dout in cycle N+2 when dout_ready is held high.
REQ-022 Throughput: one transfer per cycle under continuous valid/ready.
REQ-023 dout and dout_valid SHALL hold stable while dout_valid=1 and dout_ready=0.
REQ-024 With both stages full and dout_ready=0: din_ready=0; no input is lost or duplicated.
REQ-025 Simultaneous drain and load of a stage SHALL keep the stage full with the new data.
REQ-026 Data order SHALL be preserved; no combinational path from din to dout.

Reset
REQ-027 On rst=1 the block SHALL asynchronously clear: s1_valid=0, s2_valid=0, dout=0, op_count=0.
REQ-028 While rst=1: din_ready=1, dout_valid=0.
REQ-029 In-flight data at reset assertion SHALL be discarded and never emitted.
REQ-030 The first transfer after deassertion SHALL be accepted in the first clk edge with rst=0.

Configuration
REQ-031 Macro BIROTR_PIPE_OPCNT_EN controls the transfer counter.
REQ-032 With BIROTR_PIPE_OPCNT_EN defined: op_count increments by 1 on each cycle with dout_valid && dout_ready, wrapping 16'hFFFF to 0.
REQ-033 Without BIROTR_PIPE_OPCNT_EN: op_count is tied to 0 and no counter register exists.

Verification (HALF_W=32)
REQ-034 din=64'h0000_0000_0000_0001, shift=2, dir=0 -> dout=64'h0000_0000_8000_0000 two cycles later.
REQ-035 Same din, shift=1, dir=0 -> dout=64'h8000_0000_0000_0000.
REQ-036 Same din, shift=1, dir=1 -> dout=64'h0000_0001_0000_0000.
REQ-037 shift=0 with either dir -> dout equal to din.
REQ-038 Backpressure: 4 back-to-back inputs, dout_ready=0 for 5 cycles, then 1.
- din_ready drops after 2 accepts.
- All 4 results emerge in order with no loss.
- op_count=4 when BIROTR_PIPE_OPCNT_EN is defined.
REQ-039 rst pulsed while both stages are full -> dout_valid=0 immediately, nothing emitted, next input returns correct result 2 cycles after acceptance.
